// File: rtl/result_tx_fsm_if.sv
// ============================================================================
//  Module      : result_tx_fsm_if
//  Description : Bundles the frame-start request, result FIFO read port,
//                UART byte-send handshake and frame status flags of
//                result_tx_fsm.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface result_tx_fsm_if;
    logic        start;
    logic [3:0]  N;
    logic        fifo_empty;
    logic [15:0] fifo_data;
    logic        pop;
    logic        tx_busy;
    logic        tx_send;
    logic [7:0]  tx_data;
    logic        busy;
    logic        done;
    logic        err;

    // The framer drives the strobes and status flags.
    modport master (
        input  start, N, fifo_empty, fifo_data, tx_busy,
        output pop, tx_send, tx_data, busy, done, err
    );

    // The environment supplies requests, FIFO data and UART status.
    modport slave (
        output start, N, fifo_empty, fifo_data, tx_busy,
        input  pop, tx_send, tx_data, busy, done, err
    );
endinterface

`default_nettype wire

// File: rtl/result_tx_fsm.sv
// ============================================================================
//  Module      : result_tx_fsm
//  Description : Serialises a frame of 16-bit results from a FIFO into UART
//                bytes: FE, {0,N}, hi/lo per result, [checksum], EF.
//                Optional feature macro: RESULT_CHECKSUM_EN adds a CSUM byte
//                (XOR of length byte and all data bytes sent) before the tail.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module result_tx_fsm (
    input  wire logic       clk,
    input  wire logic       rst,
    result_tx_fsm_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_HDR     = 4'd1,
        S_LEN     = 4'd2,
        S_POP     = 4'd3,
        S_WAIT    = 4'd4,
        S_SEND_HI = 4'd5,
        S_SEND_LO = 4'd6,
        S_TAIL    = 4'd7,
`ifdef RESULT_CHECKSUM_EN
        S_DONE    = 4'd8,
        S_CSUM    = 4'd9
`else
        S_DONE    = 4'd8
`endif
    } state_t;

    localparam logic [7:0] c_hdr_byte  = 8'hFE;
    localparam logic [7:0] c_tail_byte = 8'hEF;

    // State entered once the data phase ends (normally, N=0 or underflow).
`ifdef RESULT_CHECKSUM_EN
    localparam state_t c_end_state = S_CSUM;
`else
    localparam state_t c_end_state = S_TAIL;
`endif

    state_t      r_state;
    logic        r_gap;     // second cycle of a send state: strobe out, no new send
    logic [3:0]  r_limit;
    logic [4:0]  r_count;   // 5 bits so N=15 reaches its limit without wrapping
    logic [15:0] r_hold;
`ifdef RESULT_CHECKSUM_EN
    logic [7:0]  r_csum;
`endif

    logic [7:0]  w_byte;
    logic        w_is_send;

    // Byte presented by the current send state.
    always_comb begin
        w_byte    = 8'h00;
        w_is_send = 1'b1;
        case (r_state)
            S_HDR:     w_byte = c_hdr_byte;
            S_LEN:     w_byte = {4'h0, r_limit};
            S_SEND_HI: w_byte = r_hold[15:8];
            S_SEND_LO: w_byte = r_hold[7:0];
            S_TAIL:    w_byte = c_tail_byte;
`ifdef RESULT_CHECKSUM_EN
            S_CSUM:    w_byte = r_csum;
`endif
            default:   w_is_send = 1'b0;
        endcase
    end

    // Frame sequencer with registered strobes. The pop for a result is issued
    // as POP is entered, so the strobe is high during POP and the read data is
    // present during WAIT where it gets captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_gap       <= 1'b0;
            r_limit     <= 4'h0;
            r_count     <= 5'd0;
            r_hold      <= 16'h0000;
`ifdef RESULT_CHECKSUM_EN
            r_csum      <= 8'h00;
`endif
            bus.pop     <= 1'b0;
            bus.tx_send <= 1'b0;
            bus.tx_data <= 8'h00;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.err     <= 1'b0;
        end else begin
            bus.pop     <= 1'b0;
            bus.tx_send <= 1'b0;
            bus.done    <= 1'b0;

            if (w_is_send) begin
                if (!r_gap) begin
                    if (!bus.tx_busy) begin
                        bus.tx_send <= 1'b1;
                        bus.tx_data <= w_byte;
                        r_gap       <= 1'b1;
`ifdef RESULT_CHECKSUM_EN
                        if (r_state == S_LEN || r_state == S_SEND_HI ||
                            r_state == S_SEND_LO) begin
                            r_csum <= r_csum ^ w_byte;
                        end
`endif
                    end
                end else begin
                    r_gap <= 1'b0;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_limit  <= bus.N;
                        r_count  <= 5'd0;
                        bus.err  <= 1'b0;
                        bus.busy <= 1'b1;
`ifdef RESULT_CHECKSUM_EN
                        r_csum   <= 8'h00;
`endif
                        r_state  <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (r_gap) r_state <= S_LEN;
                end
                S_LEN: begin
                    if (r_gap) begin
                        if (r_limit == 4'h0) begin
                            r_state <= c_end_state;
                        end else begin
                            bus.pop <= !bus.fifo_empty;
                            r_state <= S_POP;
                        end
                    end
                end
                S_POP: begin
                    if (bus.pop) begin
                        r_state <= S_WAIT;
                    end else begin
                        bus.err <= 1'b1;
                        r_state <= c_end_state;
                    end
                end
                S_WAIT: begin
                    r_hold  <= bus.fifo_data;
                    r_state <= S_SEND_HI;
                end
                S_SEND_HI: begin
                    if (r_gap) r_state <= S_SEND_LO;
                end
                S_SEND_LO: begin
                    if (r_gap) begin
                        r_count <= r_count + 5'd1;
                        if ((r_count + 5'd1) == {1'b0, r_limit}) begin
                            r_state <= c_end_state;
                        end else begin
                            bus.pop <= !bus.fifo_empty;
                            r_state <= S_POP;
                        end
                    end
                end
`ifdef RESULT_CHECKSUM_EN
                S_CSUM: begin
                    if (r_gap) r_state <= S_TAIL;
                end
`endif
                S_TAIL: begin
                    if (r_gap) begin
                        bus.done <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    bus.busy <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    r_gap    <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/result_tx_fsm.md
RESULT_TX_FSM -- requirements
Module: result_tx_fsm

Interface
REQ-001 The block SHALL have one clock and one reset: clk input 1 bit, rising-edge system clock; rst input 1 bit, synchronous, active-high reset.
REQ-002 Port start SHALL be input, 1 bit: one-cycle request to transmit a result frame.
REQ-003 Port N SHALL be input, 4 bits, unsigned: number of results in the frame; sampled only when a start is accepted.
REQ-004 Port fifo_empty SHALL be input, 1 bit: result FIFO is empty.
REQ-005 Port fifo_data SHALL be input, 16 bits: FIFO read data, valid one cycle after pop.
REQ-006 Port pop SHALL be output, 1 bit: one-cycle FIFO read strobe.
REQ-007 Port tx_busy SHALL be input, 1 bit: UART transmitter busy.
REQ-008 Port tx_send SHALL be output, 1 bit: one-cycle byte-send strobe.
REQ-009 Port tx_data SHALL be output, 8 bits: byte presented with tx_send.
REQ-010 Port busy SHALL be output, 1 bit: high in every state except IDLE.
REQ-011 Port done SHALL be output, 1 bit: one-cycle pulse when a frame completes.
REQ-012 Port err SHALL be output, 1 bit: sticky FIFO-underflow flag for the current frame.

Function
REQ-013 Frame byte order SHALL be 0xFE header, then the length byte {4'h0,N}, then for each result the high byte followed by the low byte, then the 0xEF tail.
REQ-014 States SHALL be IDLE, HDR, LEN, POP, WAIT, SEND_HI, SEND_LO, TAIL, DONE; each byte-send state SHALL be followed by a one-cycle GAP sub-phase.
REQ-015 Transition IDLE->HDR SHALL occur on start=1, latching N into an internal count limit and clearing the result counter and err.
REQ-016 start SHALL be ignored while busy=1.
REQ-017 In any send state, tx_send SHALL pulse for exactly one cycle, with tx_data valid, in the first cycle where tx_busy=0.
REQ-018 After each tx_send, the FSM SHALL spend exactly one GAP cycle without sending before evaluating tx_busy again.
REQ-019 After LEN, the FSM SHALL go to TAIL if N=0; otherwise it SHALL go to POP.
REQ-020 In POP, if fifo_empty=0, the block SHALL assert pop for one cycle and go to WAIT; WAIT SHALL capture fifo_data into a 16-bit holding register and go to SEND_HI.
REQ-021 In POP, if fifo_empty=1, the block SHALL set err=1, skip all remaining results and go to TAIL; it SHALL NOT pulse pop.
REQ-022 After SEND_LO, the result counter SHALL increment; the FSM SHALL go to TAIL if counter==N, else to POP.
REQ-023 The counter SHALL be 5 bits wide so that N=15 terminates without wrap-around.
REQ-024 After TAIL, the FSM SHALL go to DONE; DONE SHALL pulse done for one cycle and return to IDLE.
REQ-025 In DONE, busy SHALL still read 1.
REQ-026 pop and tx_send SHALL never be high in the same cycle.
REQ-027 Throughput: with tx_busy held 0 and the FIFO never empty, each byte SHALL take 2 cycles, and each result SHALL take 6 cycles (POP, WAIT, SEND_HI+GAP, SEND_LO+GAP).

Reset
REQ-028 While rst=1 at a clk edge: state SHALL become IDLE; pop, tx_send, busy, done and err SHALL be 0; tx_data, the holding register and the counter SHALL be 0.
REQ-029 A reset asserted mid-frame SHALL abort the frame immediately, with no tail byte and no done pulse; FIFO contents are not touched.
REQ-030 The first start accepted after rst deasserts SHALL be the start sampled on the first clock edge after deassertion.

Configuration
REQ-031 Macro RESULT_CHECKSUM_EN, when defined, SHALL insert state CSUM between the last data byte (or LEN, when N=0) and TAIL.
REQ-032 CSUM SHALL send the XOR of the length byte and all data bytes sent, using the same handshake as the other send states.
REQ-033 On underflow with RESULT_CHECKSUM_EN defined, the checksum SHALL cover only the bytes actually sent.
REQ-034 With RESULT_CHECKSUM_EN undefined, the frame SHALL be exactly as in REQ-013 and no CSUM state SHALL exist.

Verification
REQ-035 N=2, FIFO holds 0x1234 then 0xABCD, tx_busy=0 -> bytes FE 02 12 34 AB CD EF, done pulses once, err=0, pop pulses twice.
REQ-036 N=0, start -> bytes FE 00 EF, no pop, done pulses; with RESULT_CHECKSUM_EN -> FE 00 00 EF.
REQ-037 N=3, FIFO holds only 0x0001 -> bytes FE 03 00 01 EF, err=1 until next start, done pulses.
REQ-038 tx_busy held 1 for 10 cycles after the header -> tx_send stays 0 during those cycles, LEN byte sent on the first cycle tx_busy=0, no byte lost or duplicated.
REQ-039 rst pulsed while SEND_LO is waiting on tx_busy -> next cycle busy=0, tx_send=0, done=0; then a new start with N=1 and FIFO data 0x00FF -> FE 01 00 FF EF.
REQ-040 start pulsed again mid-frame with N=1 during an N=2 frame -> ignored, frame still carries length 02 and two results.
